// File: rtl/reg_to_obi_bridge.sv
// reg_to_obi_bridge: lets a register-interface master issue single
// transactions onto an OBI initiator port. One outstanding transaction,
// all outputs registered.
// Optional build macro: REG_TO_OBI_TIMEOUT_EN adds a response timeout
// and a DRAIN state that swallows the late rvalid.

package reg_to_obi_pkg;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic            write;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            valid;
  } reg_req_t;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          error;
    logic          ready;
  } reg_rsp_t;

  typedef struct packed {
    logic            req;
    logic            we;
    logic [DW/8-1:0] be;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
  } obi_req_t;

  typedef struct packed {
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;
  } obi_resp_t;
endpackage

module reg_to_obi_bridge
  import reg_to_obi_pkg::*;
#(
  parameter int AW             = reg_to_obi_pkg::AW,  // must match the struct widths
  parameter int DW             = reg_to_obi_pkg::DW,
  parameter int TIMEOUT_CYCLES = 255                  // 1..65535, timeout build only
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  reg_req_t  reg_req_i,
  output reg_rsp_t  reg_rsp_o,
  output obi_req_t  obi_req_o,
  input  obi_resp_t obi_resp_i
);

`ifdef REG_TO_OBI_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, DRAIN} state_t;
  localparam logic [DW-1:0] ERR_DATA = DW'(32'hBADC_AB1E);
  logic [15:0] cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
`endif

  state_t   state_q, state_d;
  obi_req_t obi_q, obi_d;
  reg_rsp_t rsp_q, rsp_d;

  assign obi_req_o = obi_q;
  assign reg_rsp_o = rsp_q;

  // Next-state and next-output logic; request fields and response data
  // default to holding so they stay stable between updates.
  always_comb begin
    state_d   = state_q;
    obi_d     = obi_q;
    rsp_d     = rsp_q;
    rsp_d.ready = 1'b0;
`ifdef REG_TO_OBI_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (reg_req_i.valid) begin
          obi_d.req   = 1'b1;
          obi_d.we    = reg_req_i.write;
          obi_d.addr  = reg_req_i.addr;
          obi_d.be    = reg_req_i.write ? reg_req_i.wstrb : '1;
          obi_d.wdata = reg_req_i.write ? reg_req_i.wdata : '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        // req may not be retracted before gnt, so no timeout here
        if (obi_resp_i.gnt) begin
          obi_d.req = 1'b0;
          state_d   = WAIT;
`ifdef REG_TO_OBI_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      WAIT: begin
        if (obi_resp_i.rvalid) begin
          rsp_d.ready = 1'b1;
          rsp_d.error = 1'b0;
          rsp_d.rdata = obi_q.we ? '0 : obi_resp_i.rdata;
          state_d     = RESP;
        end
`ifdef REG_TO_OBI_TIMEOUT_EN
        else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          rsp_d.ready = 1'b1;
          rsp_d.error = 1'b1;
          rsp_d.rdata = ERR_DATA;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      RESP: begin
        // valid is deliberately not sampled here; the completed request
        // must not be accepted a second time
`ifdef REG_TO_OBI_TIMEOUT_EN
        // error only comes from a timeout, so the slave still owes an rvalid
        state_d = rsp_q.error ? DRAIN : IDLE;
`else
        state_d = IDLE;
`endif
      end
`ifdef REG_TO_OBI_TIMEOUT_EN
      DRAIN: begin
        if (obi_resp_i.rvalid) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      obi_q   <= '0;
      rsp_q   <= '0;
`ifdef REG_TO_OBI_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      obi_q   <= obi_d;
      rsp_q   <= rsp_d;
`ifdef REG_TO_OBI_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_reg_to_obi_bridge.sv
// Directed bench for reg_to_obi_bridge. Timeout scenarios build only
// when REG_TO_OBI_TIMEOUT_EN is defined (DUT then uses TIMEOUT_CYCLES=4).
module tb_reg_to_obi_bridge;
  import reg_to_obi_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  reg_req_t  rq;
  reg_rsp_t  rs;
  obi_req_t  oq;
  obi_resp_t orsp;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  reg_to_obi_bridge #(.AW(32), .DW(32), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst), .reg_req_i(rq), .reg_rsp_o(rs),
    .obi_req_o(oq), .obi_resp_i(orsp)
  );

  // advance one cycle; inputs are driven and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rq = '0;
    orsp = '0;
    step();
    step();
    total++; if (oq !== '0) $display("FAIL reset_obi: got %h want 0", oq); else passed++;
    total++; if (rs !== '0) $display("FAIL reset_rsp: got %h want 0", rs); else passed++;
    rst = 1'b0;
    step();
    total++; if (oq.req !== 1'b0) $display("FAIL reset_idle_req: got %b want 0", oq.req); else passed++;
  endtask

  task automatic test_read();
    rq = '{addr:32'h0002_0004, write:1'b0, wdata:32'hFFFF_FFFF, wstrb:4'h3, valid:1'b1};
    step();                                   // cycle 1
    rq.valid = 1'b0;
    total++; if (oq.req !== 1'b1) $display("FAIL rd_req: got %b want 1", oq.req); else passed++;
    total++; if (oq.addr !== 32'h0002_0004) $display("FAIL rd_addr: got %h want 00020004", oq.addr); else passed++;
    total++; if ({oq.we, oq.be} !== 5'b0_1111) $display("FAIL rd_we_be: got %b want 01111", {oq.we, oq.be}); else passed++;
    total++; if (oq.wdata !== 32'h0) $display("FAIL rd_wdata: got %h want 0", oq.wdata); else passed++;
    orsp.gnt = 1'b1;
    step();                                   // cycle 2
    orsp.gnt = 1'b0;
    total++; if (oq.req !== 1'b0) $display("FAIL rd_req_drop: got %b want 0", oq.req); else passed++;
    total++; if (rs.ready !== 1'b0) $display("FAIL rd_early_ready: got %b want 0", rs.ready); else passed++;
    orsp.rvalid = 1'b1;
    orsp.rdata = 32'h1234_5678;
    step();                                   // cycle 3
    orsp.rvalid = 1'b0;
    orsp.rdata = 32'h0;
    total++; if (rs.ready !== 1'b1) $display("FAIL rd_ready: got %b want 1", rs.ready); else passed++;
    total++; if (rs.rdata !== 32'h1234_5678) $display("FAIL rd_rdata: got %h want 12345678", rs.rdata); else passed++;
    total++; if (rs.error !== 1'b0) $display("FAIL rd_error: got %b want 0", rs.error); else passed++;
    step();                                   // cycle 4
    total++; if (rs.ready !== 1'b0) $display("FAIL rd_ready_pulse: got %b want 0", rs.ready); else passed++;
    total++; if (rs.rdata !== 32'h1234_5678) $display("FAIL rd_rdata_hold: got %h want 12345678", rs.rdata); else passed++;
  endtask

  task automatic test_write_gnt_delay();
    rq = '{addr:32'h0001_0010, write:1'b1, wdata:32'hCAFE_F00D, wstrb:4'b0011, valid:1'b1};
    step();                                   // cycle 1
    // changes while busy must be ignored
    rq = '{addr:32'hFFFF_0000, write:1'b0, wdata:32'h0, wstrb:4'h0, valid:1'b0};
    for (int i = 0; i < 6; i++) begin          // req held cycles 1..6
      total++;
      if ({oq.req, oq.we, oq.be, oq.addr, oq.wdata} !== {1'b1, 1'b1, 4'b0011, 32'h0001_0010, 32'hCAFE_F00D})
        $display("FAIL wr_hold_%0d: got req=%b we=%b be=%h addr=%h wdata=%h want 1 1 3 00010010 cafef00d",
                 i, oq.req, oq.we, oq.be, oq.addr, oq.wdata);
      else passed++;
      orsp.gnt = (i == 5);
      step();
    end
    orsp.gnt = 1'b0;                          // cycle 7
    total++; if (oq.req !== 1'b0) $display("FAIL wr_req_drop: got %b want 0", oq.req); else passed++;
    orsp.rvalid = 1'b1;
    orsp.rdata = 32'hDEAD_BEEF;
    step();                                   // cycle 8
    orsp.rvalid = 1'b0;
    total++; if (rs.ready !== 1'b1) $display("FAIL wr_ready: got %b want 1", rs.ready); else passed++;
    total++; if (rs.rdata !== 32'h0) $display("FAIL wr_rdata: got %h want 0", rs.rdata); else passed++;
    step();
  endtask

  task automatic test_back_to_back();
    int readies = 0;
    int reqs = 0;
    rq = '{addr:32'h0000_0100, write:1'b0, wdata:32'h0, wstrb:4'h0, valid:1'b1};
    step();                                   // cycle 1: REQ
    orsp.gnt = 1'b1; step(); orsp.gnt = 1'b0; // cycle 2: WAIT
    orsp.rvalid = 1'b1; orsp.rdata = 32'h0000_00A1;
    step();                                   // cycle 3: RESP
    orsp.rvalid = 1'b0;
    total++; if (rs.ready !== 1'b1 || rs.rdata !== 32'hA1) $display("FAIL b2b_first: got ready=%b rdata=%h want 1 a1", rs.ready, rs.rdata); else passed++;
    rq.addr = 32'h0000_0200;                  // valid stays high
    step();                                   // cycle 4
    total++; if ({oq.req, rs.ready} !== 2'b00) $display("FAIL b2b_gap: got req=%b ready=%b want 0 0", oq.req, rs.ready); else passed++;
    step();                                   // cycle 5: second REQ
    total++; if (oq.req !== 1'b1 || oq.addr !== 32'h0000_0200) $display("FAIL b2b_second_req: got req=%b addr=%h want 1 00000200", oq.req, oq.addr); else passed++;
    rq.valid = 1'b0;
    orsp.gnt = 1'b1; step(); orsp.gnt = 1'b0;
    orsp.rvalid = 1'b1; orsp.rdata = 32'h0000_00B2;
    for (int i = 0; i < 6; i++) begin
      step();
      orsp.rvalid = 1'b0;
      readies += int'(rs.ready);
      reqs += int'(oq.req);
    end
    total++; if (readies !== 1) $display("FAIL b2b_ready_count: got %0d want 1", readies); else passed++;
    total++; if (reqs !== 0) $display("FAIL b2b_dup_req: got %0d want 0", reqs); else passed++;
  endtask

  task automatic test_reset_mid();
    rq = '{addr:32'h0000_0300, write:1'b0, wdata:32'h0, wstrb:4'h0, valid:1'b1};
    step();
    rq.valid = 1'b0;
    orsp.gnt = 1'b1; step(); orsp.gnt = 1'b0; // in WAIT
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (oq !== '0 || rs !== '0) $display("FAIL rst_mid_outputs: got obi=%h rsp=%h want 0 0", oq, rs); else passed++;
    orsp.rvalid = 1'b1; orsp.rdata = 32'h5555_5555;
    step();
    orsp.rvalid = 1'b0;
    step();
    total++; if (rs.ready !== 1'b0 || oq.req !== 1'b0) $display("FAIL rst_late_rvalid: got ready=%b req=%b want 0 0", rs.ready, oq.req); else passed++;
    rq = '{addr:32'h0000_0304, write:1'b0, wdata:32'h0, wstrb:4'h0, valid:1'b1};
    step();
    rq.valid = 1'b0;
    total++; if (oq.req !== 1'b1 || oq.addr !== 32'h0000_0304) $display("FAIL rst_next_req: got req=%b addr=%h want 1 00000304", oq.req, oq.addr); else passed++;
    orsp.gnt = 1'b1; step(); orsp.gnt = 1'b0;
    orsp.rvalid = 1'b1; orsp.rdata = 32'h0BAD_F00D;
    step();
    orsp.rvalid = 1'b0;
    total++; if (rs.ready !== 1'b1 || rs.rdata !== 32'h0BAD_F00D) $display("FAIL rst_next_rsp: got ready=%b rdata=%h want 1 0badf00d", rs.ready, rs.rdata); else passed++;
    step();
  endtask

`ifdef REG_TO_OBI_TIMEOUT_EN
  task automatic test_timeout();
    rq = '{addr:32'h0000_0400, write:1'b0, wdata:32'h0, wstrb:4'h0, valid:1'b1};
    step();
    rq.valid = 1'b0;
    orsp.gnt = 1'b1; step(); orsp.gnt = 1'b0; // WAIT entry, cycle w
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (rs.ready !== 1'b0) $display("FAIL to_early_%0d: got %b want 0", i, rs.ready); else passed++;
    end
    step();                                   // w+4
    total++;
    if ({rs.ready, rs.error, rs.rdata} !== {1'b1, 1'b1, 32'hBADC_AB1E})
      $display("FAIL to_resp: got ready=%b err=%b rdata=%h want 1 1 badcab1e", rs.ready, rs.error, rs.rdata);
    else passed++;
    rq = '{addr:32'h0000_0500, write:1'b0, wdata:32'h0, wstrb:4'h0, valid:1'b1};
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (oq.req !== 1'b0) $display("FAIL to_drain_%0d: got req=%b want 0", i, oq.req); else passed++;
    end
    orsp.rvalid = 1'b1; orsp.rdata = 32'h7777_7777;
    step();                                   // back to IDLE
    orsp.rvalid = 1'b0;
    total++; if (rs.ready !== 1'b0) $display("FAIL to_drain_ready: got %b want 0", rs.ready); else passed++;
    step();
    rq.valid = 1'b0;
    total++; if (oq.req !== 1'b1 || oq.addr !== 32'h0000_0500) $display("FAIL to_next_req: got req=%b addr=%h want 1 00000500", oq.req, oq.addr); else passed++;
    orsp.gnt = 1'b1; step(); orsp.gnt = 1'b0;
    orsp.rvalid = 1'b1; orsp.rdata = 32'h0000_0055;
    step();
    orsp.rvalid = 1'b0;
    total++;
    if ({rs.ready, rs.error, rs.rdata} !== {1'b1, 1'b0, 32'h55})
      $display("FAIL to_next_rsp: got ready=%b err=%b rdata=%h want 1 0 55", rs.ready, rs.error, rs.rdata);
    else passed++;
    step();
  endtask

  task automatic test_timeout_edge();
    rq = '{addr:32'h0000_0600, write:1'b0, wdata:32'h0, wstrb:4'h0, valid:1'b1};
    step();
    rq.valid = 1'b0;
    orsp.gnt = 1'b1; step(); orsp.gnt = 1'b0; // WAIT, count 0
    step(); step(); step();                   // count 3: expiry cycle
    orsp.rvalid = 1'b1; orsp.rdata = 32'h0000_0066;
    rq = '{addr:32'h0000_0700, write:1'b0, wdata:32'h0, wstrb:4'h0, valid:1'b1};
    step();
    orsp.rvalid = 1'b0;
    total++;
    if ({rs.ready, rs.error, rs.rdata} !== {1'b1, 1'b0, 32'h66})
      $display("FAIL edge_rsp: got ready=%b err=%b rdata=%h want 1 0 66", rs.ready, rs.error, rs.rdata);
    else passed++;
    step(); step();                           // IDLE then REQ, no DRAIN
    rq.valid = 1'b0;
    total++; if (oq.req !== 1'b1 || oq.addr !== 32'h0000_0700) $display("FAIL edge_no_drain: got req=%b addr=%h want 1 00000700", oq.req, oq.addr); else passed++;
    orsp.gnt = 1'b1; step(); orsp.gnt = 1'b0;
    orsp.rvalid = 1'b1; step(); orsp.rvalid = 1'b0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write_gnt_delay();
    test_back_to_back();
    test_reset_mid();
`ifdef REG_TO_OBI_TIMEOUT_EN
    test_timeout();
    test_timeout_edge();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
